// File: rtl/volleyball_match_ctrl.sv
// ============================================================================
// volleyball_match_ctrl
//
// Match-level controller for the volleyball scoreboard. Turns single-cycle
// rally events into per-team set scores, service possession, set totals and
// a match result. Sets are won by reaching the target with a two-point lead.
// The deciding fifth set uses a shorter target. After a set is won, the final
// score is held on the display for a few cycles and then the next set starts.
//
// Parameters
//   SET_PTS      target points for sets 1..4
//   FINAL_PTS    target points for the deciding set 5
//   SETS_TO_WIN  sets needed to win the match (max 3)
//   HOLD_CYCLES  cycles the finished set score stays frozen (>= 1)
//
// Ports
//   clk          clock
//   rst          asynchronous active-high reset
//   pt_a, pt_b   one-cycle rally-won pulses for team A / team B
//   undo         one-cycle pulse, revoke the last accepted point of the set
//   new_match    one-cycle pulse, synchronous restart of the whole match
//   score_a/b    current-set points per team
//   sets_a/b     sets won per team
//   set_num      current set, 1..5
//   set_inc_a/b  one-cycle pulse when that team wins a set
//   serve        0 = A serving, 1 = B serving
//   match_done   high once the match has been decided
//   winner       match winner (0 = A, 1 = B), valid while match_done is high
// ============================================================================
module volleyball_match_ctrl #(
    parameter int SET_PTS     = 25,
    parameter int FINAL_PTS   = 15,
    parameter int SETS_TO_WIN = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pt_a,
    input  logic       pt_b,
    input  logic       undo,
    input  logic       new_match,
    output logic [5:0] score_a,
    output logic [5:0] score_b,
    output logic [1:0] sets_a,
    output logic [1:0] sets_b,
    output logic [2:0] set_num,
    output logic       set_inc_a,
    output logic       set_inc_b,
    output logic       serve,
    output logic       match_done,
    output logic       winner
);

    localparam logic [1:0] ST_PLAY      = 2'd0;
    localparam logic [1:0] ST_SET_END   = 2'd1;
    localparam logic [1:0] ST_MATCH_END = 2'd2;

    // The hold counter runs 0..HOLD_CYCLES-1 while the set score is frozen.
    localparam int              HOLD_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [6:0] SET_TARGET   = 7'(SET_PTS);
    localparam logic [6:0] FINAL_TARGET = 7'(FINAL_PTS);
    localparam logic [1:0] SETS_GOAL    = 2'(SETS_TO_WIN);
    localparam logic [5:0] SCORE_MAX    = 6'd63;

    // Registered state
    logic [1:0]        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hist_valid;
    logic              hist_team;
    logic              hist_serve;

    // Next-state values
    logic [1:0]        state_d;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              hist_valid_d;
    logic              hist_team_d;
    logic              hist_serve_d;
    logic [5:0]        score_a_d;
    logic [5:0]        score_b_d;
    logic [1:0]        sets_a_d;
    logic [1:0]        sets_b_d;
    logic [2:0]        set_num_d;
    logic              set_inc_a_d;
    logic              set_inc_b_d;
    logic              serve_d;
    logic              match_done_d;
    logic              winner_d;

    // Point evaluation helpers. A point is only meaningful when exactly one
    // team pulses; pt_b doubles as the scorer's team index in that case.
    logic       point_valid;
    logic       scorer;
    logic [5:0] win_cur;
    logic [5:0] lose_cur;
    logic [6:0] win_new;
    logic [6:0] target;
    logic       set_won;
    logic [1:0] sets_new;
    logic [2:0] set_num_next;
    logic       undo_ok;

    assign point_valid  = pt_a ^ pt_b;
    assign scorer       = pt_b;
    assign win_cur      = scorer ? score_b : score_a;
    assign lose_cur     = scorer ? score_a : score_b;
    assign win_new      = {1'b0, win_cur} + 7'd1;
    assign target       = (set_num == 3'd5) ? FINAL_TARGET : SET_TARGET;
    // Win check uses the post-increment score, widened so the +2 lead test
    // cannot wrap.
    assign set_won      = (win_new >= target) && (win_new >= ({1'b0, lose_cur} + 7'd2));
    assign sets_new     = scorer ? (sets_b + 2'd1) : (sets_a + 2'd1);
    assign set_num_next = set_num + 3'd1;
    // Undo yields to any simultaneous point pulse, including a conflicting pair.
    assign undo_ok      = undo && !pt_a && !pt_b && hist_valid;

    // Next-state computation. new_match overrides everything at the end so it
    // behaves as a synchronous restart from any state.
    always_comb begin
        state_d      = state;
        hold_cnt_d   = hold_cnt;
        hist_valid_d = hist_valid;
        hist_team_d  = hist_team;
        hist_serve_d = hist_serve;
        score_a_d    = score_a;
        score_b_d    = score_b;
        sets_a_d     = sets_a;
        sets_b_d     = sets_b;
        set_num_d    = set_num;
        set_inc_a_d  = 1'b0;
        set_inc_b_d  = 1'b0;
        serve_d      = serve;
        match_done_d = match_done;
        winner_d     = winner;

        case (state)
            ST_PLAY: begin
                if (point_valid) begin
                    // A saturated score swallows the point without touching
                    // history, so a later undo still revokes the older point.
                    if (win_cur != SCORE_MAX) begin
                        if (scorer) begin
                            score_b_d = win_new[5:0];
                        end else begin
                            score_a_d = win_new[5:0];
                        end
                        serve_d      = scorer;
                        hist_valid_d = 1'b1;
                        hist_team_d  = scorer;
                        hist_serve_d = serve;

                        if (set_won) begin
                            if (scorer) begin
                                sets_b_d    = sets_new;
                                set_inc_b_d = 1'b1;
                            end else begin
                                sets_a_d    = sets_new;
                                set_inc_a_d = 1'b1;
                            end
                            if (sets_new == SETS_GOAL) begin
                                state_d      = ST_MATCH_END;
                                match_done_d = 1'b1;
                                winner_d     = scorer;
                            end else begin
                                state_d    = ST_SET_END;
                                hold_cnt_d = '0;
                            end
                        end
                    end
                end else if (undo_ok) begin
                    if (hist_team) begin
                        score_b_d = score_b - 6'd1;
                    end else begin
                        score_a_d = score_a - 6'd1;
                    end
                    serve_d      = hist_serve;
                    hist_valid_d = 1'b0;
                end
            end

            ST_SET_END: begin
                if (hold_cnt == HOLD_LAST) begin
                    score_a_d    = '0;
                    score_b_d    = '0;
                    set_num_d    = set_num_next;
                    hist_valid_d = 1'b0;
                    // Odd sets open with A serving, even sets with B.
                    serve_d      = ~set_num_next[0];
                    state_d      = ST_PLAY;
                end else begin
                    hold_cnt_d = hold_cnt + HOLD_W'(1);
                end
            end

            ST_MATCH_END: begin
            end

            default: begin
                state_d = ST_PLAY;
            end
        endcase

        if (new_match) begin
            state_d      = ST_PLAY;
            hold_cnt_d   = '0;
            hist_valid_d = 1'b0;
            hist_team_d  = 1'b0;
            hist_serve_d = 1'b0;
            score_a_d    = '0;
            score_b_d    = '0;
            sets_a_d     = '0;
            sets_b_d     = '0;
            set_num_d    = 3'd1;
            set_inc_a_d  = 1'b0;
            set_inc_b_d  = 1'b0;
            serve_d      = 1'b0;
            match_done_d = 1'b0;
            winner_d     = 1'b0;
        end
    end

    // State and output registers; every output is driven straight from here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_PLAY;
            hold_cnt   <= '0;
            hist_valid <= 1'b0;
            hist_team  <= 1'b0;
            hist_serve <= 1'b0;
            score_a    <= '0;
            score_b    <= '0;
            sets_a     <= '0;
            sets_b     <= '0;
            set_num    <= 3'd1;
            set_inc_a  <= 1'b0;
            set_inc_b  <= 1'b0;
            serve      <= 1'b0;
            match_done <= 1'b0;
            winner     <= 1'b0;
        end else begin
            state      <= state_d;
            hold_cnt   <= hold_cnt_d;
            hist_valid <= hist_valid_d;
            hist_team  <= hist_team_d;
            hist_serve <= hist_serve_d;
            score_a    <= score_a_d;
            score_b    <= score_b_d;
            sets_a     <= sets_a_d;
            sets_b     <= sets_b_d;
            set_num    <= set_num_d;
            set_inc_a  <= set_inc_a_d;
            set_inc_b  <= set_inc_b_d;
            serve      <= serve_d;
            match_done <= match_done_d;
            winner     <= winner_d;
        end
    end

endmodule

// File: tb/tb_volleyball_match_ctrl.sv
// ============================================================================
// tb_volleyball_match_ctrl
//
// Self-checking bench for volleyball_match_ctrl with default parameters.
// A rules-level scoreboard model tracks the match as plain integers and a
// history queue; every falling edge the DUT outputs are compared against it.
// Directed sequences also pin key outcomes with literal expectations.
// ============================================================================
module tb_volleyball_match_ctrl;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic       pt_a;
    logic       pt_b;
    logic       undo;
    logic       new_match;
    logic [5:0] score_a;
    logic [5:0] score_b;
    logic [1:0] sets_a;
    logic [1:0] sets_b;
    logic [2:0] set_num;
    logic       set_inc_a;
    logic       set_inc_b;
    logic       serve;
    logic       match_done;
    logic       winner;

    int  pass_cnt  = 0;
    int  total_cnt = 0;
    bit  compare_en = 1'b0;

    volleyball_match_ctrl #(
        .SET_PTS    (25),
        .FINAL_PTS  (15),
        .SETS_TO_WIN(3),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pt_a      (pt_a),
        .pt_b      (pt_b),
        .undo      (undo),
        .new_match (new_match),
        .score_a   (score_a),
        .score_b   (score_b),
        .sets_a    (sets_a),
        .sets_b    (sets_b),
        .set_num   (set_num),
        .set_inc_a (set_inc_a),
        .set_inc_b (set_inc_b),
        .serve     (serve),
        .match_done(match_done),
        .winner    (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Rules-level model of the match
    // ------------------------------------------------------------------
    typedef struct {
        int team;
        int srv;
    } hist_t;

    int    m_score[2];
    int    m_sets[2];
    int    m_inc[2];
    int    m_set;
    int    m_serve;
    int    m_done;
    int    m_win;
    int    m_hold_left;
    hist_t m_hist[$];

    task automatic modelReset();
        m_score[0] = 0; m_score[1] = 0;
        m_sets[0]  = 0; m_sets[1]  = 0;
        m_inc[0]   = 0; m_inc[1]   = 0;
        m_set       = 1;
        m_serve     = 0;
        m_done      = 0;
        m_win       = 0;
        m_hold_left = 0;
        m_hist.delete();
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst || new_match) begin
            modelReset();
        end else begin
            m_inc[0] = 0;
            m_inc[1] = 0;
            if (m_done != 0) begin
                // match decided, everything frozen
            end else if (m_hold_left > 0) begin
                m_hold_left = m_hold_left - 1;
                if (m_hold_left == 0) begin
                    m_score[0] = 0;
                    m_score[1] = 0;
                    m_set      = m_set + 1;
                    m_serve    = (m_set % 2 == 1) ? 0 : 1;
                    m_hist.delete();
                end
            end else if (pt_a != pt_b) begin
                int t;
                int tgt;
                t = pt_b ? 1 : 0;
                if (m_score[t] < 63) begin
                    m_score[t] = m_score[t] + 1;
                    m_hist.delete();
                    m_hist.push_back('{team: t, srv: m_serve});
                    m_serve = t;
                    tgt = (m_set == 5) ? 15 : 25;
                    if (m_score[t] >= tgt && m_score[t] - m_score[1-t] >= 2) begin
                        m_sets[t] = m_sets[t] + 1;
                        m_inc[t]  = 1;
                        if (m_sets[t] == 3) begin
                            m_done = 1;
                            m_win  = t;
                        end else begin
                            m_hold_left = HOLD;
                        end
                    end
                end
            end else if (undo && !pt_a && !pt_b && m_hist.size() > 0) begin
                hist_t h;
                h = m_hist.pop_back();
                m_score[h.team] = m_score[h.team] - 1;
                m_serve = h.srv;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic checkOutput(input string name, input int actual, input int expected);
        total_cnt = total_cnt + 1;
        if (actual == expected) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (compare_en) begin
            checkOutput("cyc score_a",    int'(score_a),    m_score[0]);
            checkOutput("cyc score_b",    int'(score_b),    m_score[1]);
            checkOutput("cyc sets_a",     int'(sets_a),     m_sets[0]);
            checkOutput("cyc sets_b",     int'(sets_b),     m_sets[1]);
            checkOutput("cyc set_num",    int'(set_num),    m_set);
            checkOutput("cyc set_inc_a",  int'(set_inc_a),  m_inc[0]);
            checkOutput("cyc set_inc_b",  int'(set_inc_b),  m_inc[1]);
            checkOutput("cyc serve",      int'(serve),      m_serve);
            checkOutput("cyc match_done", int'(match_done), m_done);
            if (m_done != 0) begin
                checkOutput("cyc winner", int'(winner), m_win);
            end
        end
    end

    // Drive one cycle of inputs: set after a falling edge, release just
    // after the following rising edge so the DUT samples them exactly once.
    task automatic applyStimulus(input logic a, input logic b, input logic u, input logic nm);
        @(negedge clk);
        pt_a      = a;
        pt_b      = b;
        undo      = u;
        new_match = nm;
        @(posedge clk);
        #1;
        pt_a      = 1'b0;
        pt_b      = 1'b0;
        undo      = 1'b0;
        new_match = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pointsA(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pointsB(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " score_a"},    int'(score_a),    0);
        checkOutput({tag, " score_b"},    int'(score_b),    0);
        checkOutput({tag, " sets_a"},     int'(sets_a),     0);
        checkOutput({tag, " sets_b"},     int'(sets_b),     0);
        checkOutput({tag, " set_num"},    int'(set_num),    1);
        checkOutput({tag, " serve"},      int'(serve),      0);
        checkOutput({tag, " set_inc_a"},  int'(set_inc_a),  0);
        checkOutput({tag, " set_inc_b"},  int'(set_inc_b),  0);
        checkOutput({tag, " match_done"}, int'(match_done), 0);
        checkOutput({tag, " winner"},     int'(winner),     0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst       = 1'b1;
        pt_a      = 1'b0;
        pt_b      = 1'b0;
        undo      = 1'b0;
        new_match = 1'b0;
        #12;
        rst = 1'b0;
        #1;
        checkReset("reset");
        compare_en = 1'b1;

        // Set 1: straight win for A
        pointsA(24);
        checkOutput("set1 24-0 no win", int'(sets_a), 0);
        pointsA(1);
        checkOutput("set1 score_a",   int'(score_a),   25);
        checkOutput("set1 sets_a",    int'(sets_a),    1);
        checkOutput("set1 set_inc_a", int'(set_inc_a), 1);
        // Point during the hold is ignored (hold edge 1)
        pointsA(1);
        checkOutput("hold pt ignored", int'(score_a),   25);
        checkOutput("set_inc one cyc", int'(set_inc_a), 0);
        idle(HOLD - 2);
        checkOutput("hold still frozen", int'(score_a), 25);
        idle(1);
        checkOutput("set2 score_a", int'(score_a), 0);
        checkOutput("set2 set_num", int'(set_num), 2);
        checkOutput("set2 serve",   int'(serve),   1);

        // Set 2: deuce
        for (int i = 0; i < 24; i++) begin
            pointsA(1);
            pointsB(1);
        end
        pointsA(1);
        checkOutput("deuce 25-24 no win", int'(sets_a), 1);
        pointsB(1);
        pointsA(1);
        checkOutput("deuce 26-25 no win", int'(sets_a), 1);
        pointsA(1);
        checkOutput("deuce score_a", int'(score_a), 27);
        checkOutput("deuce score_b", int'(score_b), 25);
        checkOutput("deuce sets_a",  int'(sets_a),  2);
        idle(HOLD);
        checkOutput("set3 set_num", int'(set_num), 3);
        checkOutput("set3 serve",   int'(serve),   0);

        // Set 3: undo and conflicts, then B wins
        pointsB(7);
        pointsA(10);
        checkOutput("undo pre serve", int'(serve), 0);
        pointsB(1);
        checkOutput("undo pt_b score_b", int'(score_b), 8);
        checkOutput("undo pt_b serve",   int'(serve),   1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("undo1 score_b", int'(score_b), 7);
        checkOutput("undo1 serve",   int'(serve),   0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("undo2 score_a", int'(score_a), 10);
        checkOutput("undo2 score_b", int'(score_b), 7);
        checkOutput("undo2 serve",   int'(serve),   0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("both pts score_a", int'(score_a), 10);
        checkOutput("both pts score_b", int'(score_b), 7);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("pt+undo score_a", int'(score_a), 11);
        pointsB(18);
        checkOutput("set3 sets_b",     int'(sets_b),    1);
        checkOutput("set3 set_inc_b",  int'(set_inc_b), 1);
        checkOutput("set3 set_inc_a",  int'(set_inc_a), 0);
        idle(HOLD);
        checkOutput("set4 serve", int'(serve), 1);

        // Set 4: B straight
        pointsB(25);
        checkOutput("set4 sets_b", int'(sets_b), 2);
        idle(HOLD);
        checkOutput("set5 set_num", int'(set_num), 5);
        checkOutput("set5 serve",   int'(serve),   0);

        // Set 5: deciding set to 15
        for (int i = 0; i < 13; i++) begin
            pointsA(1);
            pointsB(1);
        end
        pointsA(1);
        checkOutput("final 14-13 sets_a", int'(sets_a),     2);
        checkOutput("final 14-13 done",   int'(match_done), 0);
        pointsA(1);
        checkOutput("final score_a", int'(score_a),    15);
        checkOutput("final sets_a",  int'(sets_a),     3);
        checkOutput("final done",    int'(match_done), 1);
        checkOutput("final winner",  int'(winner),     0);
        pointsB(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("match_end frozen b", int'(score_b), 13);
        checkOutput("match_end frozen a", int'(score_a), 15);
        checkOutput("match_end inc off",  int'(set_inc_a), 0);

        // new_match from MATCH_END
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkReset("new_match");

        // rst mid-hold
        pointsA(25);
        idle(2);
        #2;
        rst = 1'b1;
        #1;
        checkReset("rst midhold");
        #3;
        rst = 1'b0;
        pointsB(1);
        checkOutput("post rst score_b", int'(score_b), 1);
        checkOutput("post rst serve",   int'(serve),   1);
        idle(2);

        compare_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
